// File: rtl/tour_move_sequencer_if.sv
// Command-path bundle between UART_wrapper, the tour move sequencer and cmd_proc.
//   cmd_UART / cmd_rdy_UART / clr_cmd_rdy_UART : command arriving from the UART side
//   cmd / cmd_rdy / clr_cmd_rdy                : command presented to cmd_proc
//   send_resp / resp                           : completion strobe and response byte
// The master modport is the sequencer; the slave modport is its environment
// (UART_wrapper plus cmd_proc).
interface tour_move_sequencer_if;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (
        input  cmd_UART,
        input  cmd_rdy_UART,
        output clr_cmd_rdy_UART,
        output cmd,
        output cmd_rdy,
        input  clr_cmd_rdy,
        input  send_resp,
        output resp
    );

    modport slave (
        output cmd_UART,
        output cmd_rdy_UART,
        input  clr_cmd_rdy_UART,
        input  cmd,
        input  cmd_rdy,
        output clr_cmd_rdy,
        output send_resp,
        input  resp
    );
endinterface

// File: rtl/tour_move_sequencer.sv
// Tour move sequencer: passes UART commands straight to cmd_proc while idle,
// and after start_tour replays the solved knight's tour one move at a time.
// Each one-hot move becomes a vertical-leg command (opcode 4'h4) followed by
// a horizontal-leg command (opcode 4'h5, with fanfare).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start_tour  : one-cycle pulse, tour solved, begin replay
//   move        : one-hot move read from tour memory at mv_indx
//   mv_indx     : move index presented to tour memory
//   tour_err    : one-cycle pulse when a non-one-hot move is read
//   bus         : UART / cmd_proc command path (master modport)
module tour_move_sequencer #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_tour,
    input  logic [7:0]            move,
    output logic [IDX_W-1:0]      mv_indx,
    output logic                  tour_err,
    tour_move_sequencer_if.master bus
);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MOVES - 1);

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERT   = 3'd2,
        ST_WAIT_V = 3'd3,
        ST_HORZ   = 3'd4,
        ST_WAIT_H = 3'd5
    } state_t;

    state_t           state_r, state_s;
    logic [IDX_W-1:0] mv_indx_r, mv_indx_s;
    logic [7:0]       move_r, move_s;
    logic             tour_err_r, tour_err_s;
    logic             last_move_s;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_one_hot(input logic [7:0] m);
        return (m != 8'h00) && ((m & (m - 8'h01)) == 8'h00);
    endfunction

    // Vertical leg of a knight move: north/south by one or two squares.
    function automatic logic [15:0] vert_leg(input logic [7:0] m);
        logic [15:0] leg;
        case (m)
            8'h01, 8'h02: leg = {4'h4, HDG_N, 4'h2};
            8'h04, 8'h80: leg = {4'h4, HDG_N, 4'h1};
            8'h08, 8'h40: leg = {4'h4, HDG_S, 4'h1};
            8'h10, 8'h20: leg = {4'h4, HDG_S, 4'h2};
            default:      leg = 16'h0000;
        endcase
        return leg;
    endfunction

    // Horizontal leg of a knight move: east/west by one or two squares.
    function automatic logic [15:0] horz_leg(input logic [7:0] m);
        logic [15:0] leg;
        case (m)
            8'h01, 8'h20: leg = {4'h5, HDG_E, 4'h1};
            8'h02, 8'h10: leg = {4'h5, HDG_W, 4'h1};
            8'h04, 8'h08: leg = {4'h5, HDG_W, 4'h2};
            8'h40, 8'h80: leg = {4'h5, HDG_E, 4'h2};
            default:      leg = 16'h0000;
        endcase
        return leg;
    endfunction

    assign last_move_s = (mv_indx_r == IDX_LAST);
    assign mv_indx     = mv_indx_r;
    assign tour_err    = tour_err_r;

    // State, move index, captured move and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            mv_indx_r  <= IDX_ZERO;
            move_r     <= 8'h00;
            tour_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            mv_indx_r  <= mv_indx_s;
            move_r     <= move_s;
            tour_err_r <= tour_err_s;
        end
    end

    // Next-state logic; each state reacts only to the strobe that is meaningful
    // to it, so stray clr_cmd_rdy/send_resp/start_tour pulses never skip a leg.
    always_comb begin
        state_s    = state_r;
        mv_indx_s  = mv_indx_r;
        move_s     = move_r;
        tour_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_tour) begin
                    mv_indx_s = IDX_ZERO;
                    state_s   = ST_LOAD;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_LOAD: begin
                move_s = move;
                if (is_one_hot(move)) begin
                    state_s    = ST_VERT;
                end else begin
                    tour_err_s = 1'b1;
                    state_s    = ST_IDLE;
                end
            end
            ST_VERT: begin
                if (bus.clr_cmd_rdy) begin
                    state_s = ST_WAIT_V;
                end else begin
                    state_s = ST_VERT;
                end
            end
            ST_WAIT_V: begin
                if (bus.send_resp) begin
                    state_s = ST_HORZ;
                end else begin
                    state_s = ST_WAIT_V;
                end
            end
            ST_HORZ: begin
                if (bus.clr_cmd_rdy) begin
                    state_s = ST_WAIT_H;
                end else begin
                    state_s = ST_HORZ;
                end
            end
            ST_WAIT_H: begin
                if (bus.send_resp && last_move_s) begin
                    mv_indx_s = IDX_ZERO;
                    state_s   = ST_IDLE;
                end else if (bus.send_resp) begin
                    mv_indx_s = mv_indx_r + IDX_ONE;
                    state_s   = ST_LOAD;
                end else begin
                    state_s   = ST_WAIT_H;
                end
            end
            default: begin
                mv_indx_s = IDX_ZERO;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // Output mux: UART pass-through in IDLE, leg commands during the tour.
    // The UART ack is suppressed outside IDLE so a pending command waits.
    always_comb begin
        bus.cmd              = vert_leg(move_r);
        bus.cmd_rdy          = 1'b0;
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.resp             = 8'h5A;
        case (state_r)
            ST_IDLE: begin
                bus.cmd              = bus.cmd_UART;
                bus.cmd_rdy          = bus.cmd_rdy_UART;
                bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
                bus.resp             = 8'hA5;
            end
            ST_LOAD, ST_WAIT_V: begin
                bus.cmd = vert_leg(move_r);
            end
            ST_VERT: begin
                bus.cmd     = vert_leg(move_r);
                bus.cmd_rdy = 1'b1;
            end
            ST_HORZ: begin
                bus.cmd     = horz_leg(move_r);
                bus.cmd_rdy = 1'b1;
            end
            ST_WAIT_H: begin
                bus.cmd = horz_leg(move_r);
                if (last_move_s) begin
                    bus.resp = 8'hA5;
                end else begin
                    bus.resp = 8'h5A;
                end
            end
            default: begin
                bus.cmd  = bus.cmd_UART;
                bus.resp = 8'hA5;
            end
        endcase
    end

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Directed bench for tour_move_sequencer: UART pass-through, tour replay with
// a scoreboard of expected leg commands, tour_err handling and mid-tour reset.
module tb_tour_move_sequencer;
    localparam int NUM_MOVES = 24;
    localparam int IDX_W     = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_tour;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic             tour_err;
    logic [7:0]       tour_mem [0:31];
    logic [15:0]      sb_q [$];
    int               checks   = 0;
    int               failures = 0;

    tour_move_sequencer_if bus ();

    always #5 clk = ~clk;

    assign move = tour_mem[mv_indx];

    tour_move_sequencer #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_tour (start_tour),
        .move       (move),
        .mv_indx    (mv_indx),
        .tour_err   (tour_err),
        .bus        (bus)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sb_pop();
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_underflow observed=empty expected=entry");
            return 16'hxxxx;
        end
        return sb_q.pop_front();
    endfunction

    function automatic void push_lit(input logic [15:0] v, input logic [15:0] h);
        sb_q.push_back(v);
        sb_q.push_back(h);
    endfunction

    // Knight displacement (north/east positive) turned into the two legs.
    function automatic void push_model(input logic [7:0] m);
        int b = -1;
        int dy, dx, ay, ax;
        for (int i = 0; i < 8; i++) if (m[i]) b = i;
        case (b)
            0: begin dy =  2; dx =  1; end
            1: begin dy =  2; dx = -1; end
            2: begin dy =  1; dx = -2; end
            3: begin dy = -1; dx = -2; end
            4: begin dy = -2; dx = -1; end
            5: begin dy = -2; dx =  1; end
            6: begin dy = -1; dx =  2; end
            7: begin dy =  1; dx =  2; end
            default: begin dy = 0; dx = 0; end
        endcase
        ay = (dy < 0) ? -dy : dy;
        ax = (dx < 0) ? -dx : dx;
        sb_q.push_back({4'h4, (dy > 0) ? 8'h00 : 8'h7F, 4'(ay)});
        sb_q.push_back({4'h5, (dx > 0) ? 8'hBF : 8'h3F, 4'(ax)});
    endfunction

    // Entered with the DUT in LOAD for move idx; leaves it one cycle after
    // the final send_resp (LOAD of the next move, or IDLE after the last).
    task automatic play_move(input int idx, input bit probe);
        logic [15:0] ev, eh, er;
        ev = sb_pop();
        eh = sb_pop();
        er = (idx == NUM_MOVES - 1) ? 16'h00A5 : 16'h005A;
        chk($sformatf("m%0d_load_rdy", idx), 16'(bus.cmd_rdy), 16'h0000);
        chk($sformatf("m%0d_mv_indx", idx), 16'(mv_indx), 16'(idx));
        cycle();
        chk($sformatf("m%0d_vert_rdy", idx), 16'(bus.cmd_rdy), 16'h0001);
        chk($sformatf("m%0d_vert_cmd", idx), bus.cmd, ev);
        chk($sformatf("m%0d_vert_resp", idx), 16'(bus.resp), 16'h005A);
        if (probe) begin
            bus.send_resp = 1'b1;
            start_tour    = 1'b1;
            cycle();
            bus.send_resp = 1'b0;
            start_tour    = 1'b0;
            chk("probe_vert_rdy", 16'(bus.cmd_rdy), 16'h0001);
            chk("probe_vert_cmd", bus.cmd, ev);
        end
        bus.clr_cmd_rdy = 1'b1;
        #1;
        chk($sformatf("m%0d_uart_clr", idx), 16'(bus.clr_cmd_rdy_UART), 16'h0000);
        cycle();
        bus.clr_cmd_rdy = 1'b0;
        chk($sformatf("m%0d_waitv_rdy", idx), 16'(bus.cmd_rdy), 16'h0000);
        chk($sformatf("m%0d_waitv_cmd", idx), bus.cmd, ev);
        if (probe) begin
            bus.clr_cmd_rdy = 1'b1;
            cycle();
            chk("probe_waitv_rdy", 16'(bus.cmd_rdy), 16'h0000);
            chk("probe_waitv_cmd", bus.cmd, ev);
        end
        bus.send_resp = 1'b1;
        #1;
        chk($sformatf("m%0d_waitv_resp", idx), 16'(bus.resp), 16'h005A);
        cycle();
        bus.send_resp   = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        chk($sformatf("m%0d_horz_rdy", idx), 16'(bus.cmd_rdy), 16'h0001);
        chk($sformatf("m%0d_horz_cmd", idx), bus.cmd, eh);
        bus.clr_cmd_rdy = 1'b1;
        cycle();
        bus.clr_cmd_rdy = 1'b0;
        chk($sformatf("m%0d_waith_rdy", idx), 16'(bus.cmd_rdy), 16'h0000);
        chk($sformatf("m%0d_waith_cmd", idx), bus.cmd, eh);
        chk($sformatf("m%0d_waith_resp", idx), 16'(bus.resp), er);
        bus.send_resp = 1'b1;
        cycle();
        bus.send_resp = 1'b0;
    endtask

    task automatic push_first_five();
        push_lit(16'h4002, 16'h5BF1);
        push_lit(16'h47F1, 16'h53F2);
        push_lit(16'h47F2, 16'h53F1);
        push_lit(16'h47F1, 16'h5BF2);
        push_lit(16'h4001, 16'h5BF2);
    endtask

    initial begin
        logic [7:0]  one;
        logic [15:0] ev, eh;
        one = 8'h01;
        rst = 1'b1;
        start_tour = 1'b0;
        bus.cmd_UART = 16'h0000;
        bus.cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp = 1'b0;
        for (int i = 0; i < 32; i++) tour_mem[i] = 8'h01;
        tour_mem[0] = 8'h01;
        tour_mem[1] = 8'h08;
        tour_mem[2] = 8'h10;
        tour_mem[3] = 8'h40;
        tour_mem[4] = 8'h80;
        for (int i = 5; i < NUM_MOVES; i++) tour_mem[i] = one << $urandom_range(7, 0);
        cycle();
        cycle();
        chk("rst_mv_indx", 16'(mv_indx), 16'h0000);
        chk("rst_tour_err", 16'(tour_err), 16'h0000);
        chk("rst_resp", 16'(bus.resp), 16'h00A5);
        chk("rst_cmd_rdy", 16'(bus.cmd_rdy), 16'h0000);
        rst = 1'b0;
        cycle();

        // Idle pass-through
        bus.cmd_UART = 16'h2000;
        bus.cmd_rdy_UART = 1'b1;
        #1;
        chk("idle_cmd", bus.cmd, 16'h2000);
        chk("idle_cmd_rdy", 16'(bus.cmd_rdy), 16'h0001);
        chk("idle_resp", 16'(bus.resp), 16'h00A5);
        bus.clr_cmd_rdy = 1'b1;
        #1;
        chk("idle_clr_uart", 16'(bus.clr_cmd_rdy_UART), 16'h0001);
        cycle();
        bus.clr_cmd_rdy = 1'b0;
        bus.cmd_rdy_UART = 1'b0;
        #1;
        chk("idle_clr_uart_low", 16'(bus.clr_cmd_rdy_UART), 16'h0000);

        // Full tour with a UART command held pending throughout
        push_first_five();
        for (int i = 5; i < NUM_MOVES; i++) push_model(tour_mem[i]);
        bus.cmd_UART = 16'h3123;
        bus.cmd_rdy_UART = 1'b1;
        start_tour = 1'b1;
        cycle();
        start_tour = 1'b0;
        for (int i = 0; i < NUM_MOVES; i++) play_move(i, i == 0);
        chk("tour_end_mv_indx", 16'(mv_indx), 16'h0000);
        chk("tour_end_cmd_rdy", 16'(bus.cmd_rdy), 16'h0001);
        chk("tour_end_cmd", bus.cmd, 16'h3123);
        chk("tour_end_resp", 16'(bus.resp), 16'h00A5);
        chk("tour_end_sb_empty", 16'(sb_q.size()), 16'h0000);
        bus.clr_cmd_rdy = 1'b1;
        #1;
        chk("tour_end_clr_uart", 16'(bus.clr_cmd_rdy_UART), 16'h0001);
        cycle();
        bus.clr_cmd_rdy = 1'b0;
        bus.cmd_rdy_UART = 1'b0;

        // Non-one-hot move at index 5
        tour_mem[5] = 8'h03;
        push_first_five();
        start_tour = 1'b1;
        cycle();
        start_tour = 1'b0;
        for (int i = 0; i < 5; i++) play_move(i, 1'b0);
        chk("err_load_idx", 16'(mv_indx), 16'h0005);
        chk("err_load_rdy", 16'(bus.cmd_rdy), 16'h0000);
        cycle();
        chk("err_pulse", 16'(tour_err), 16'h0001);
        chk("err_rdy0", 16'(bus.cmd_rdy), 16'h0000);
        chk("err_resp", 16'(bus.resp), 16'h00A5);
        cycle();
        chk("err_pulse_end", 16'(tour_err), 16'h0000);
        chk("err_rdy1", 16'(bus.cmd_rdy), 16'h0000);

        // Reset while waiting on the vertical leg of move 7
        tour_mem[5] = 8'h20;
        tour_mem[6] = 8'h02;
        tour_mem[7] = 8'h04;
        push_first_five();
        push_model(tour_mem[5]);
        push_model(tour_mem[6]);
        push_model(tour_mem[7]);
        bus.cmd_UART = 16'h2ABC;
        bus.cmd_rdy_UART = 1'b1;
        start_tour = 1'b1;
        cycle();
        start_tour = 1'b0;
        for (int i = 0; i < 7; i++) play_move(i, 1'b0);
        ev = sb_pop();
        eh = sb_pop();
        chk("m7_mv_indx", 16'(mv_indx), 16'h0007);
        cycle();
        chk("m7_vert_rdy", 16'(bus.cmd_rdy), 16'h0001);
        chk("m7_vert_cmd", bus.cmd, ev);
        bus.clr_cmd_rdy = 1'b1;
        cycle();
        bus.clr_cmd_rdy = 1'b0;
        chk("m7_waitv_rdy", 16'(bus.cmd_rdy), 16'h0000);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mrst_mv_indx", 16'(mv_indx), 16'h0000);
        chk("mrst_tour_err", 16'(tour_err), 16'h0000);
        chk("mrst_cmd_rdy", 16'(bus.cmd_rdy), 16'h0001);
        chk("mrst_cmd", bus.cmd, 16'h2ABC);
        chk("mrst_resp", 16'(bus.resp), 16'h00A5);
        bus.cmd_rdy_UART = 1'b0;
        #1;
        chk("mrst_rdy_follow", 16'(bus.cmd_rdy), 16'h0000);
        cycle();
        chk("mrst_no_reissue", 16'(bus.cmd_rdy), 16'h0000);
        chk("mrst_horz_not_out", bus.cmd, 16'h2ABC);
        if (eh == 16'h0000) chk("m7_horz_model", eh, 16'h53F2);

        // Restart after reset
        push_lit(16'h4002, 16'h5BF1);
        start_tour = 1'b1;
        cycle();
        start_tour = 1'b0;
        play_move(0, 1'b0);
        chk("restart_next_idx", 16'(mv_indx), 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tour_move_sequencer.md
Name: tour_move_sequencer

Overview:
- Sits between the UART command path (UART_wrapper), tour logic (move memory) and cmd_proc in KnightsTour.
- In idle it passes UART commands straight through to cmd_proc.
- After start_tour it replays the solved tour one move at a time.
- Each knight move becomes two cmd_proc commands, vertical leg first and then horizontal leg, with the correct response byte returned to the remote.

Parameters:
NUM_MOVES, 24, number of moves in a tour (5x5 board); last index is NUM_MOVES-1
IDX_W, 5, width of mv_indx

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_tour  in  1  one-cycle pulse from cmd_proc: tour solved, begin replay
move  in  8  one-hot move read from tour logic at address mv_indx
mv_indx  out  IDX_W  move index presented to tour logic
cmd_UART  in  16  command from UART_wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy_UART  out  1  acknowledge/consume UART command
cmd  out  16  command to cmd_proc
cmd_rdy  out  1  command valid to cmd_proc
clr_cmd_rdy  in  1  cmd_proc accepted cmd
send_resp  in  1  cmd_proc finished current command
resp  out  8  response byte to UART_wrapper
tour_err  out  1  one-cycle pulse: non-one-hot move read

Behaviour:
- Reset values:
  - state=IDLE, mv_indx=0, move register=0, tour_err=0.
  - Outputs then follow IDLE pass-through: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5.
- Command format: cmd[15:12] opcode, cmd[11:4] heading, cmd[3:0] squares.
  - Vertical leg: opcode 4'h4 (move).
  - Horizontal leg: opcode 4'h5 (move with fanfare).
  - Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Move decode (bit: vertical leg, horizontal leg):
  - 0: N2, E1
  - 1: N2, W1
  - 2: N1, W2
  - 3: S1, W2
  - 4: S2, W1
  - 5: S2, E1
  - 6: S1, E2
  - 7: N1, E2
  - Worked examples: bit0 gives 16'h4002 then 16'h5BF1; bit3 gives 16'h47F1 then 16'h53F2.
- IDLE:
  - Mux selects the UART path; clr_cmd_rdy_UART=clr_cmd_rdy.
  - start_tour: mv_indx<=0, go to LOAD.
- LOAD (1 cycle, covers tour-memory read latency):
  - Register move.
  - Not exactly one bit set: pulse tour_err, go to IDLE.
  - Otherwise go to VERT.
- VERT:
  - cmd=vertical leg, cmd_rdy=1.
  - clr_cmd_rdy: go to WAIT_V.
- WAIT_V:
  - cmd held, cmd_rdy=0.
  - send_resp: go to HORZ.
- HORZ:
  - cmd=horizontal leg, cmd_rdy=1.
  - clr_cmd_rdy: go to WAIT_H.
- WAIT_H:
  - cmd held, cmd_rdy=0.
  - send_resp with mv_indx==NUM_MOVES-1: go to IDLE, mv_indx<=0.
  - send_resp otherwise: mv_indx<=mv_indx+1, go to LOAD.
- Latency:
  - cmd_rdy for the first leg rises 2 cycles after the start_tour pulse (LOAD, then VERT).
  - Between moves, 2 cycles from send_resp to the next cmd_rdy.
- resp:
  - 8'hA5 in IDLE.
  - 8'h5A in all tour states.
  - Exception: WAIT_H with mv_indx==NUM_MOVES-1 gives 8'hA5 (tour done).
  - resp is sampled by UART_wrapper on send_resp.
- Outside IDLE:
  - clr_cmd_rdy_UART=0; a pending UART command stays pending and is not lost.
  - It is delivered after return to IDLE.
- Boundary conditions:
  - start_tour outside IDLE is ignored.
  - clr_cmd_rdy in WAIT_V/WAIT_H is ignored.
  - send_resp in VERT/HORZ is ignored (no leg skipping).
  - clr_cmd_rdy and send_resp in the same cycle: only the transition valid for the current state is taken.
  - mv_indx never exceeds NUM_MOVES-1.
  - rst mid-tour: next cycle IDLE, mv_indx=0, cmd_rdy follows cmd_rdy_UART; no partial leg is reissued.

Test Plan:
- Reset, then cmd_UART=16'h2000, cmd_rdy_UART=1 -> cmd=16'h2000, cmd_rdy=1; clr_cmd_rdy pulse drives clr_cmd_rdy_UART=1 the same cycle; resp=8'hA5.
- start_tour with move=8'h01 -> 2 cycles later cmd=16'h4002, cmd_rdy=1. Then:
  - clr_cmd_rdy, then send_resp -> cmd=16'h5BF1, cmd_rdy=1.
  - resp=8'h5A throughout.
- Moves 8'h08, 8'h10, 8'h40, 8'h80 at indices 1-4 -> leg pairs in order:
  - 47F1/53F2
  - 47F2/53F1
  - 47F1/5BF2
  - 4001/5BF2
  - mv_indx steps 1,2,3,4.
- Full 24-move tour: final WAIT_H gives resp=8'hA5; after send_resp, state IDLE and mv_indx=0. Hold cmd_rdy_UART=1 during the tour: clr_cmd_rdy_UART stays 0 until IDLE.
- move=8'h03 at index 5 -> tour_err pulses 1 cycle, return to IDLE, no cmd_rdy issued for that move.
- rst asserted in WAIT_V at index 7 -> next cycle IDLE, mv_indx=0, tour_err=0. A second start_tour then restarts from index 0 with the correct first command.
